// File: rtl/sumlatch_uart_pkg.sv
// Shared types and constants for the sum-latch UART receiver.
// Build option: UART_RX_PARITY_EN adds the PARITY state (8E1 frames).
package sumlatch_uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY    = 3'd3,
`endif
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_e;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sumlatch_uart_rx_if.sv
// Receiver-to-consumer bundle: byte output, status flags and the ready input.
// Handshake: rx_data is valid while rx_valid=1 and is held stable until an edge
// with rx_valid=1 and rx_ready=1 consumes it; rx_valid never depends on rx_ready.
interface sumlatch_uart_rx_if;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   modport master (
      input  rx_ready,
      output rx_data, rx_valid, rx_busy, frame_err, overrun, parity_err
   );

   modport slave (
      output rx_ready,
      input  rx_data, rx_valid, rx_busy, frame_err, overrun, parity_err
   );
endinterface

// File: rtl/sumlatch_uart_rx_sync.sv
// Two-flop synchronizer for asynchronous active-low/idle-high inputs.
// Resets to 1 so a reset never looks like a falling edge.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/sumlatch_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready output.
// Build option: UART_RX_PARITY_EN selects 8E1 frames and enables parity_err.
module sumlatch_uart_rx
   import sumlatch_uart_pkg::*;
#(
   parameter int CLK_FREQ  = 10_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               uart_rxd,
   sumlatch_uart_rx_if.master rx,
   output rx_state_e          dbg_state
);
   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   logic          rxd_s;
   rx_state_e     state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_cnt, bit_n;
   logic [7:0]    shreg, shreg_n;
   logic          par_bad, par_bad_n;
   logic          stop_good, frame_hit, par_hit;
   logic [7:0]    data_q;
   logic          valid_q, fe_q, ov_q, pe_q;

   uart_rx_sync u_sync (.clk(clk), .reset(reset), .d(uart_rxd), .q(rxd_s));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bad <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_cnt <= bit_n;
         shreg   <= shreg_n;
         par_bad <= par_bad_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CW'(1);
      bit_n     = bit_cnt;
      shreg_n   = shreg;
      par_bad_n = par_bad;
      stop_good = 1'b0;
      frame_hit = 1'b0;
      par_hit   = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_n     = '0;
            bit_n     = '0;
            par_bad_n = 1'b0;
            if (!rxd_s) state_n = ST_START;
         end
         ST_START: begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (cnt == HALF_M1) begin
               cnt_n   = '0;
               state_n = rxd_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt == FULL_M1) begin
               cnt_n   = '0;
               shreg_n = {rxd_s, shreg[7:1]};
               bit_n   = bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_cnt == LAST_BIT) state_n = ST_PARITY;
`else
               if (bit_cnt == LAST_BIT) state_n = ST_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt == FULL_M1) begin
               cnt_n     = '0;
               par_bad_n = (rxd_s != ^shreg);
               state_n   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt == FULL_M1) begin
               cnt_n = '0;
               if (!rxd_s) begin
                  frame_hit = 1'b1;
                  state_n   = ST_WAIT_IDLE;
               end else if (par_bad) begin
                  par_hit = 1'b1;
                  state_n = ST_IDLE;
               end else begin
                  stop_good = 1'b1;
                  state_n   = ST_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            cnt_n = '0;
            if (rxd_s) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // A byte landing on the same edge the old one is consumed replaces it.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
         pe_q    <= 1'b0;
      end else begin
         fe_q <= frame_hit;
         pe_q <= par_hit;
         ov_q <= 1'b0;
         if (stop_good) begin
            if (!valid_q || rx.rx_ready) begin
               data_q  <= shreg;
               valid_q <= 1'b1;
            end else begin
               ov_q <= 1'b1;
            end
         end else if (valid_q && rx.rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx.rx_data   = data_q;
   assign rx.rx_valid  = valid_q;
   assign rx.rx_busy   = (state != ST_IDLE);
   assign rx.frame_err = fe_q;
   assign rx.overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
   assign rx.parity_err = pe_q;
`else
   assign rx.parity_err = 1'b0;
`endif
   assign dbg_state = state;
endmodule

// File: tb/tb_sumlatch_uart_rx.sv
// Directed bench for sumlatch_uart_rx at N = 16 clocks per bit.
// Define UART_RX_PARITY_EN for both RTL and bench to exercise 8E1 frames.
module tb_sumlatch_uart_rx;
   import sumlatch_uart_pkg::*;

   logic      clk = 1'b0;
   logic      reset = 1'b1;
   logic      uart_rxd = 1'b1;
   rx_state_e dbg_state;
   int        cyc = 0;
   int        checks = 0;
   int        failures = 0;
   int        fall_cyc = 0;

   // observation counters, written only by the monitor
   int         valid_rises = 0, valid_hi = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, busy_cnt = 0;
   int         valid_cyc = 0;
   logic [7:0] last_data = 8'h00;
   logic       prev_valid = 1'b0;

   // snapshots taken by the stimulus
   int s_vr, s_vh, s_fe, s_ov, s_pe, s_busy;

   sumlatch_uart_rx_if rx ();

   sumlatch_uart_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
      .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .rx(rx.master), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx.rx_valid && !prev_valid) begin
         valid_rises = valid_rises + 1;
         valid_cyc   = cyc;
         last_data   = rx.rx_data;
      end
      if (rx.rx_valid)   valid_hi = valid_hi + 1;
      if (rx.frame_err)  fe_cnt = fe_cnt + 1;
      if (rx.overrun)    ov_cnt = ov_cnt + 1;
      if (rx.parity_err) pe_cnt = pe_cnt + 1;
      if (rx.rx_busy)    busy_cnt = busy_cnt + 1;
      prev_valid = rx.rx_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_vr = valid_rises; s_vh = valid_hi; s_fe = fe_cnt;
      s_ov = ov_cnt; s_pe = pe_cnt; s_busy = busy_cnt;
   endtask

   // driver tasks
   task automatic hold_bit(input logic v);
      uart_rxd = v;
      repeat (16) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      @(posedge clk); #1;
      fall_cyc = cyc;
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      hold_bit(par);
`else
      if (par === 1'bx) hold_bit(1'b1);
`endif
      hold_bit(stop);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rx.rx_ready = 1'b0;
      idle(3);
      @(negedge clk);
      check("reset_rx_data",    rx.rx_data,    8'h00);
      check("reset_rx_valid",   rx.rx_valid,   0);
      check("reset_rx_busy",    rx.rx_busy,    0);
      check("reset_frame_err",  rx.frame_err,  0);
      check("reset_overrun",    rx.overrun,    0);
      check("reset_parity_err", rx.parity_err, 0);
      @(posedge clk); #1 reset = 1'b0;
      idle(5);

      // 1: 0xA5 with consumer always ready
      rx.rx_ready = 1'b1;
      snap();
      send_frame(8'hA5, 1'b0, 1'b1);
      idle(20);
      check("t1_valid_rises", valid_rises - s_vr, 1);
      check("t1_valid_cycles", valid_hi - s_vh, 1);
      check("t1_data", last_data, 8'hA5);
      check("t1_latency", valid_cyc - fall_cyc, 155);
      check("t1_no_errors", (fe_cnt - s_fe) + (ov_cnt - s_ov) + (pe_cnt - s_pe), 0);

      // 2: back-to-back 0x3C, 0x7E with consumer stalled
      rx.rx_ready = 1'b0;
      snap();
      send_frame(8'h3C, 1'b0, 1'b1);
      send_frame(8'h7E, 1'b0, 1'b1);
      idle(20);
      @(negedge clk);
      check("t2_overrun_once", ov_cnt - s_ov, 1);
      check("t2_valid_held", rx.rx_valid, 1);
      check("t2_data_first", rx.rx_data, 8'h3C);
      @(posedge clk); #1 rx.rx_ready = 1'b1;
      @(posedge clk); #1 rx.rx_ready = 1'b0;
      @(negedge clk);
      check("t2_valid_dropped", rx.rx_valid, 0);
      check("t2_valid_rises", valid_rises - s_vr, 1);

      // 3: stop bit low, line low 20 bit-times, then a good 0x55
      rx.rx_ready = 1'b1;
      snap();
      send_frame(8'h00, 1'b0, 1'b0);
      idle(160);
      uart_rxd = 1'b1;
      idle(20);
      check("t3_frame_err", fe_cnt - s_fe, 1);
      check("t3_no_valid", valid_rises - s_vr, 0);
      check("t3_idle_after_break", rx.rx_busy, 0);
      snap();
      send_frame(8'h55, 1'b0, 1'b1);
      idle(20);
      check("t3_recover_valid", valid_rises - s_vr, 1);
      check("t3_recover_data", last_data, 8'h55);
      check("t3_recover_no_fe", fe_cnt - s_fe, 0);

      // 4: 4-cycle glitch on the idle line
      snap();
      @(posedge clk); #1 uart_rxd = 1'b0;
      idle(4);
      uart_rxd = 1'b1;
      idle(30);
      check("t4_busy_bounded", ((busy_cnt - s_busy) >= 1 && (busy_cnt - s_busy) <= 10) ? 1 : 0, 1);
      check("t4_back_idle", rx.rx_busy, 0);
      check("t4_no_outputs", (valid_rises - s_vr) + (fe_cnt - s_fe) + (ov_cnt - s_ov), 0);
      check("t4_data_unchanged", rx.rx_data, 8'h55);

      // 5: reset during bit 4 of 0xF0 while a byte is held, then 0x81
      rx.rx_ready = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b1);
      idle(5);
      check("t5_held_before_reset", rx.rx_valid, 1);
      @(posedge clk); #1;
      hold_bit(1'b0);
      for (int i = 0; i < 4; i++) hold_bit(1'b0);
      uart_rxd = 1'b1;
      idle(8);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("t5_reset_valid", rx.rx_valid, 0);
      check("t5_reset_data", rx.rx_data, 8'h00);
      check("t5_reset_busy", rx.rx_busy, 0);
      snap();
      idle(100);
      check("t5_quiet_after_reset", (valid_rises - s_vr) + (fe_cnt - s_fe), 0);
      rx.rx_ready = 1'b1;
      send_frame(8'h81, 1'b0, 1'b1);
      idle(20);
      check("t5_valid", valid_rises - s_vr, 1);
      check("t5_data", last_data, 8'h81);

`ifdef UART_RX_PARITY_EN
      // 6: even parity, 0x07 carries parity bit 1
      snap();
      send_frame(8'h07, 1'b1, 1'b1);
      idle(20);
      check("t6_good_valid", valid_rises - s_vr, 1);
      check("t6_good_data", last_data, 8'h07);
      check("t6_good_no_pe", pe_cnt - s_pe, 0);
      snap();
      send_frame(8'h07, 1'b0, 1'b1);
      idle(20);
      check("t6_bad_pe", pe_cnt - s_pe, 1);
      check("t6_bad_no_valid", valid_rises - s_vr, 0);
`else
      check("t6_parity_never", pe_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
